// File: rtl/bath_request_ctrl_if.sv
// bath_request_ctrl_if: button pulses, delay-block acknowledges and status outputs of the lock request controller.
interface bath_request_ctrl_if #(parameter int OCC_W = 2);
    logic             arrive_req;
    logic             depart_req;
    logic             arriving;
    logic             departing;
    logic             clr_err;
    logic [1:0]       bathysphereSignal;
    logic             busy;
    logic [OCC_W-1:0] occupancy;
    logic             rejected;
    logic             timeout_err;
    modport master (
        input  arrive_req, depart_req, arriving, departing, clr_err,
        output bathysphereSignal, busy, occupancy, rejected, timeout_err
    );
    modport slave (
        output arrive_req, depart_req, arriving, departing, clr_err,
        input  bathysphereSignal, busy, occupancy, rejected, timeout_err
    );
endinterface

// File: rtl/bath_request_ctrl.sv
// bath_request_ctrl: holds arrive/depart requests to the delay block until acknowledged, tracking lock occupancy.
// Define BATH_REQ_QUEUE_EN to keep one request that arrives mid-handshake instead of rejecting it.
module bath_request_ctrl #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int MAX_OCC        = 3,
    parameter int OCC_W          = 2
) (
    input logic                 clk,
    input logic                 reset,
    bath_request_ctrl_if.master bus
);
`ifdef BATH_REQ_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif
    localparam int               TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(MAX_OCC);

    typedef enum logic [1:0] {IDLE, REQ_ARR, REQ_DEP, RELEASE} state_t;

    state_t           r_state, w_state_nxt;
    logic [TW-1:0]    r_timer, w_timer_nxt;
    logic [OCC_W-1:0] r_occ, w_occ_nxt;
    logic [1:0]       r_sig;
    logic             r_busy, r_rej, r_err, r_pend_v, r_pend_dep;
    logic             w_rej, w_err_set, w_pend_v_nxt, w_pend_dep_nxt;
    logic             w_req_arr, w_req_dep, w_xtra_arr, w_xtra_dep;
    logic             w_occ_full, w_occ_empty;

    assign w_occ_full  = r_occ >= OCC_MAX;
    assign w_occ_empty = r_occ == '0;

    // Split this cycle's pulses into the request served from IDLE and leftovers handled as busy requests.
    always_comb begin
        w_req_arr  = 1'b0;
        w_req_dep  = 1'b0;
        w_xtra_arr = bus.arrive_req;
        w_xtra_dep = bus.depart_req;
        if (r_state == IDLE) begin
            if (r_pend_v) begin
                w_req_dep = r_pend_dep;
                w_req_arr = !r_pend_dep;
            end else if (bus.depart_req && !w_occ_empty) begin
                w_req_dep  = 1'b1;
                w_xtra_dep = 1'b0;
            end else begin
                w_req_dep  = bus.depart_req;
                w_req_arr  = bus.arrive_req;
                w_xtra_dep = 1'b0;
                w_xtra_arr = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = '0;
        w_occ_nxt      = r_occ;
        w_err_set      = 1'b0;
        w_rej          = 1'b0;
        w_pend_v_nxt   = r_pend_v;
        w_pend_dep_nxt = r_pend_dep;
        case (r_state)
            IDLE: begin
                w_pend_v_nxt = 1'b0;
                if (w_req_dep && !w_occ_empty)
                    w_state_nxt = REQ_DEP;
                else if (w_req_arr && !w_occ_full)
                    w_state_nxt = REQ_ARR;
                w_rej = (w_req_dep && w_occ_empty) || (w_req_arr && w_occ_full);
            end
            REQ_ARR, REQ_DEP: begin
                w_timer_nxt = r_timer + 1'b1;
                if (r_state == REQ_ARR ? bus.arriving : bus.departing) begin
                    w_occ_nxt   = r_state == REQ_ARR ? (w_occ_full ? r_occ : r_occ + 1'b1)
                                                     : (w_occ_empty ? r_occ : r_occ - 1'b1);
                    w_state_nxt = RELEASE;
                end else if (bus.arriving || bus.departing || r_timer == T_LAST) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end
            default: if (!bus.arriving && !bus.departing) w_state_nxt = IDLE;
        endcase
        if (w_xtra_arr || w_xtra_dep) begin
            if (QUEUE_EN && !r_pend_v) begin
                w_pend_v_nxt   = 1'b1;
                w_pend_dep_nxt = w_xtra_dep;
                w_rej          = w_rej || (w_xtra_arr && w_xtra_dep);
            end else begin
                w_rej = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_occ      <= '0;
            r_sig      <= 2'b00;
            r_busy     <= 1'b0;
            r_rej      <= 1'b0;
            r_err      <= 1'b0;
            r_pend_v   <= 1'b0;
            r_pend_dep <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_occ      <= w_occ_nxt;
            r_sig      <= w_state_nxt == REQ_ARR ? 2'b01 : w_state_nxt == REQ_DEP ? 2'b10 : 2'b00;
            r_busy     <= w_state_nxt != IDLE;
            r_rej      <= w_rej;
            r_err      <= w_err_set || (r_err && !bus.clr_err);
            r_pend_v   <= w_pend_v_nxt;
            r_pend_dep <= w_pend_dep_nxt;
        end
    end

    assign bus.bathysphereSignal = r_sig;
    assign bus.busy              = r_busy;
    assign bus.occupancy         = r_occ;
    assign bus.rejected          = r_rej;
    assign bus.timeout_err       = r_err;
endmodule

// File: tb/tb_bath_request_ctrl.sv
// tb_bath_request_ctrl: directed and random lock traffic, scored against an occupancy/handshake model.
`timescale 1ns/1ps
module tb_bath_request_ctrl;
    localparam int TIMEOUT = 40;
    localparam int MAXOCC  = 3;

    typedef struct {
        int occ;
        int hold;
    } done_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bath_request_ctrl_if #(.OCC_W(2)) bus ();
    bath_request_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_OCC(MAXOCC), .OCC_W(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int    q_req[$];
    done_t q_done[$];
    int    q_rej[$];
    int    q_err[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    model_occ = 0;
    bit    model_err = 1'b0;
    int    ack_mode = 0;
    int    ack_delay = 5;
    int    ack_tail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Delay block: ack (or the opposite ack, or nothing) ack_delay cycles after a request, held ack_tail extra cycles.
    initial begin
        int cnt, tail;
        cnt = 0;
        tail = 0;
        bus.arriving = 1'b0;
        bus.departing = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0;
                bus.arriving = 1'b0;
                bus.departing = 1'b0;
            end else if (bus.bathysphereSignal != 2'b00) begin
                cnt++;
                if (ack_mode != 1 && cnt >= ack_delay) begin
                    bus.arriving  = (bus.bathysphereSignal == 2'b01) ^ (ack_mode == 2);
                    bus.departing = (bus.bathysphereSignal == 2'b10) ^ (ack_mode == 2);
                    tail = ack_tail;
                end
            end else begin
                cnt = 0;
                if (tail > 0) tail--;
                else begin
                    bus.arriving = 1'b0;
                    bus.departing = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [1:0] prev;
        bit         prev_err;
        int         hold;
        done_t      d;
        prev = 2'b00;
        prev_err = 1'b0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = 2'b00;
                prev_err = 1'b0;
                hold = 0;
            end else begin
                if (prev == 2'b00 && bus.bathysphereSignal != 2'b00) begin
                    hold = 0;
                    if (q_req.size() == 0) check("unexpected request", 32'(bus.bathysphereSignal), 0);
                    else check("request direction", 32'(bus.bathysphereSignal), q_req.pop_front());
                end
                if (bus.bathysphereSignal != 2'b00) hold++;
                if (prev != 2'b00 && bus.bathysphereSignal == 2'b00) begin
                    if (q_done.size() == 0) check("unexpected release", 32'(prev), 0);
                    else begin
                        d = q_done.pop_front();
                        check("occupancy after handshake", 32'(bus.occupancy), d.occ);
                        check("request hold cycles", hold, d.hold);
                    end
                end
                if (bus.rejected) begin
                    if (q_rej.size() == 0) check("unexpected reject", 32'(bus.rejected), 0);
                    else check("busy at reject", 32'(bus.busy), q_rej.pop_front());
                end
                if (bus.timeout_err && !prev_err) begin
                    if (q_err.size() == 0) check("unexpected timeout_err", 32'(bus.timeout_err), 0);
                    else check("occupancy at timeout_err", 32'(bus.occupancy), q_err.pop_front());
                end
                prev = bus.bathysphereSignal;
                prev_err = bus.timeout_err;
            end
        end
    end

    task automatic pulse(input bit arr, input bit dep);
        @(negedge clk);
        bus.arrive_req = arr;
        bus.depart_req = dep;
        @(negedge clk);
        bus.arrive_req = 1'b0;
        bus.depart_req = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = (!bus.busy && bus.bathysphereSignal == 2'b00 && !bus.arriving && !bus.departing) ? quiet + 1 : 0;
        end
        check("idle within budget", 32'(quiet >= 3), 1);
    endtask

    task automatic expect_done(input bit dep, input int mode, input int delay);
        bit    ok;
        done_t d;
        ok = mode == 0 && delay <= TIMEOUT;
        if (ok) model_occ += dep ? -1 : 1;
        else if (!model_err) begin
            q_err.push_back(model_occ);
            model_err = 1'b1;
        end
        d.occ = model_occ;
        d.hold = (mode == 1 || delay > TIMEOUT) ? TIMEOUT : delay;
        q_done.push_back(d);
    endtask

    task automatic txn(input bit dep, input int mode, input int delay, input int tail);
        bit legal;
        legal = dep ? model_occ > 0 : model_occ < MAXOCC;
        ack_mode = mode;
        ack_delay = delay;
        ack_tail = tail;
        if (legal) begin
            q_req.push_back(dep ? 2 : 1);
            expect_done(dep, mode, delay);
        end else q_rej.push_back(0);
        pulse(!dep, dep);
        if (!legal) check("signal after reject", 32'(bus.bathysphereSignal), 0);
        wait_idle();
    endtask

    task automatic clear_err();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        check("timeout_err cleared", 32'(bus.timeout_err), 0);
        model_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        bus.arrive_req = 1'b0;
        bus.depart_req = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset signal", 32'(bus.bathysphereSignal), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset occupancy", 32'(bus.occupancy), 0);
        check("reset rejected", 32'(bus.rejected), 0);
        check("reset timeout_err", 32'(bus.timeout_err), 0);

        // Reset mid REQ_ARR: outputs clear at once, the aborted arrival never counts.
        txn(0, 0, 5, 0);
        ack_mode = 1;
        q_req.push_back(1);
        pulse(1, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async reset signal", 32'(bus.bathysphereSignal), 0);
        check("async reset busy", 32'(bus.busy), 0);
        check("async reset occupancy", 32'(bus.occupancy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_occ = 0;
        model_err = 1'b0;
        ack_mode = 0;
        @(negedge clk);
        check("occupancy after reset release", 32'(bus.occupancy), 0);

        repeat (4) txn(0, 0, 5, 0);
        repeat (4) txn(1, 0, 5, 0);
        txn(0, 0, 5, 0);
        txn(1, 0, 5, 0);

        txn(0, 1, 5, 0);
        check("timeout_err after no ack", 32'(bus.timeout_err), 1);
        clear_err();
        txn(0, 0, TIMEOUT, 0);
        txn(0, 0, TIMEOUT + 1, 0);
        check("timeout_err one cycle late", 32'(bus.timeout_err), 1);
        clear_err();

        while (model_occ < 2) txn(0, 0, 5, 0);
        while (model_occ > 2) txn(1, 0, 5, 0);
        ack_mode = 0;
        ack_delay = 5;
        ack_tail = 0;
        q_req.push_back(2);
        expect_done(1, 0, 5);
`ifdef BATH_REQ_QUEUE_EN
        q_req.push_back(1);
        expect_done(0, 0, 5);
`else
        q_rej.push_back(1);
`endif
        pulse(1, 1);
        wait_idle();
        check("occupancy after simultaneous pulses", 32'(bus.occupancy), model_occ);

        // Arriving during a depart: error, and RELEASE lasts as long as the stray ack.
        ack_mode = 2;
        ack_delay = 5;
        ack_tail = 4;
        q_req.push_back(2);
        expect_done(1, 2, 5);
        pulse(0, 1);
        for (int i = 0; i < 100 && bus.bathysphereSignal != 2'b00; i++) @(negedge clk);
        rel = 0;
        for (int i = 0; i < 100 && bus.busy; i++) begin
            rel++;
            @(negedge clk);
        end
        check("release held while ack high", rel, ack_tail + 1);
        check("timeout_err after wrong ack", 32'(bus.timeout_err), 1);
        wait_idle();
        clear_err();

        for (int t = 0; t < 60; t++) begin
            int r, mode;
            r = $urandom_range(0, 9);
            mode = r < 7 ? 0 : (r < 8 ? 1 : 2);
            txn(1'($urandom_range(0, 1)), mode, $urandom_range(1, 12), $urandom_range(0, 3));
            if (model_err && $urandom_range(0, 1) == 1) clear_err();
        end

        repeat (5) @(negedge clk);
        check("final occupancy", 32'(bus.occupancy), model_occ);
        check("leftover request expectations", q_req.size(), 0);
        check("leftover release expectations", q_done.size(), 0);
        check("leftover reject expectations", q_rej.size(), 0);
        check("leftover error expectations", q_err.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
